// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding and grant-width helper.
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  // A single requester still needs a 1-bit grant index.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching last+1, last+2, ... modulo N.
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic          valid_o,
  output logic [GW-1:0] idx_o
);

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % N);
  endfunction

  // Walk from the lowest priority to the highest so the last hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[wrap_add(last_i, i)]) begin
        valid_o = 1'b1;
        idx_o   = wrap_add(last_i, i);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one downstream APB master port among NUM_MASTERS requesters with a
// round-robin grant that is locked for a whole SETUP/ACCESS/return transfer.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter  int BUS_WIDTH   = 16,
  parameter  int NUM_MASTERS = 2,
  localparam int GW          = grant_width(NUM_MASTERS)
) (
  input  logic                             S_PCLK,
  input  logic                             S_PRESETn,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [NUM_MASTERS-1:0]           S_PWRITE,
  input  logic [NUM_MASTERS-1:0]           S_PSELx,
  input  logic [NUM_MASTERS-1:0]           S_PENABLE,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0]             S_PRDATA,
  output logic [NUM_MASTERS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]             M_PADDR,
  output logic                             M_PWRITE,
  output logic                             M_PSELx,
  output logic                             M_PENABLE,
  output logic [BUS_WIDTH-1:0]             M_PWDATA,
  input  logic [BUS_WIDTH-1:0]             M_PRDATA,
  input  logic                             M_PREADY,
  output logic [GW-1:0]                    M_GRANT,
  output arb_state_e                       dbg_state_o
);

  arb_state_e           state_q;
  logic [GW-1:0]        last_q;
  logic [GW-1:0]        grant_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 write_q;
  logic                 psel_q;
  logic                 penable_q;

  logic [BUS_WIDTH-1:0] req_addr  [NUM_MASTERS];
  logic [BUS_WIDTH-1:0] req_wdata [NUM_MASTERS];
  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic                 done_leave;
  logic [NUM_MASTERS-1:0] pready;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign req_addr[i]  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
    assign req_wdata[i] = S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
  end

  rr_priority_pick #(
    .N  (NUM_MASTERS),
    .GW (GW)
  ) u_pick (
    .req_i   (S_PSELx),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Leave DONE when the requester completes its access phase or abandons it.
  assign done_leave = !S_PSELx[grant_q] || S_PENABLE[grant_q];

  always_ff @(posedge S_PCLK or negedge S_PRESETn) begin
    if (!S_PRESETn) begin
      state_q   <= ARB_IDLE;
      last_q    <= GW'(NUM_MASTERS - 1);
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            addr_q  <= req_addr[pick_idx];
            wdata_q <= req_wdata[pick_idx];
            write_q <= S_PWRITE[pick_idx];
            psel_q  <= 1'b1;
            state_q <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (M_PREADY) begin
            rdata_q   <= M_PRDATA;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          if (done_leave) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    pready = '0;
    if (state_q == ARB_DONE && S_PSELx[grant_q] && S_PENABLE[grant_q]) begin
      pready[grant_q] = 1'b1;
    end
  end

  assign S_PREADY    = pready;
  assign S_PRDATA    = (|pready) ? rdata_q : '0;
  assign M_PADDR     = addr_q;
  assign M_PWRITE    = write_q;
  assign M_PWDATA    = wdata_q;
  assign M_PSELx     = psel_q;
  assign M_PENABLE   = penable_q;
  assign M_GRANT     = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: two requesters, a downstream slave model
// with programmable wait states, and a scoreboard of expected downstream transfers.
module tb_apb_master_arbiter;
  import apb_master_arbiter_pkg::*;

  localparam int SBW = 34;

  logic        clk = 1'b0;
  logic        S_PRESETn;
  logic [31:0] S_PADDR;
  logic [1:0]  S_PWRITE;
  logic [1:0]  S_PSELx;
  logic [1:0]  S_PENABLE;
  logic [31:0] S_PWDATA;
  logic [15:0] S_PRDATA;
  logic [1:0]  S_PREADY;
  logic [15:0] M_PADDR;
  logic        M_PWRITE;
  logic        M_PSELx;
  logic        M_PENABLE;
  logic [15:0] M_PWDATA;
  logic [15:0] M_PRDATA;
  logic        M_PREADY;
  logic        M_GRANT;
  arb_state_e  dbg_state;

  logic [SBW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int wait_states = 0;
  int acc_cnt = 0;
  int pen_cycles = 0;
  int m1_rdy = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(.BUS_WIDTH(16), .NUM_MASTERS(2)) dut (
    .S_PCLK      (clk),
    .S_PRESETn   (S_PRESETn),
    .S_PADDR     (S_PADDR),
    .S_PWRITE    (S_PWRITE),
    .S_PSELx     (S_PSELx),
    .S_PENABLE   (S_PENABLE),
    .S_PWDATA    (S_PWDATA),
    .S_PRDATA    (S_PRDATA),
    .S_PREADY    (S_PREADY),
    .M_PADDR     (M_PADDR),
    .M_PWRITE    (M_PWRITE),
    .M_PSELx     (M_PSELx),
    .M_PENABLE   (M_PENABLE),
    .M_PWDATA    (M_PWDATA),
    .M_PRDATA    (M_PRDATA),
    .M_PREADY    (M_PREADY),
    .M_GRANT     (M_GRANT),
    .dbg_state_o (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] slave_data(input logic [15:0] a);
    return (a == 16'h0093) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  task automatic sb_push(input int m, input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic [0:0] g;
    g = m[0];
    exp_q.push_back({g, wr, a, d});
  endtask

  // Downstream slave: ready after wait_states extra ACCESS cycles, checks each completed transfer.
  always @(negedge clk) begin
    logic [SBW-1:0] exp_w;
    if (M_PSELx && M_PENABLE) begin
      if (acc_cnt >= wait_states) begin
        M_PREADY = 1'b1;
        M_PRDATA = slave_data(M_PADDR);
        acc_cnt  = 0;
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("downstream_xfer", {M_GRANT, M_PWRITE, M_PADDR, M_PWDATA}, exp_w);
        end
      end else begin
        M_PREADY = 1'b0;
        acc_cnt++;
      end
    end else begin
      M_PREADY = 1'b0;
      M_PRDATA = 16'h0;
      acc_cnt  = 0;
    end
  end

  // Upstream return-path monitor.
  always @(negedge clk) begin
    if (M_PENABLE) pen_cycles++;
    if (S_PREADY != 2'b00) check_eq("pready_onehot", $onehot0(S_PREADY), 1);
    else check_eq("prdata_idle_zero", S_PRDATA, 0);
  end

  task automatic do_reset();
    S_PRESETn = 1'b0;
    S_PSELx   = '0;
    S_PENABLE = '0;
    S_PWRITE  = '0;
    S_PADDR   = '0;
    S_PWDATA  = '0;
    repeat (2) @(posedge clk);
    #1;
    S_PRESETn = 1'b1;
  endtask

  // One APB transfer from requester m; returns at posedge+1 after PSEL is dropped.
  task automatic apb_req(input int m, input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit done;
    S_PSELx[m] = 1'b1;
    S_PWRITE[m] = wr;
    S_PADDR[m*16 +: 16] = a;
    S_PWDATA[m*16 +: 16] = d;
    @(posedge clk); #1;
    S_PENABLE[m] = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (S_PREADY[m]) begin
        done = 1'b1;
        check_eq("pready_vec", S_PREADY, 2'b01 << m);
        if (!wr) check_eq("read_data", S_PRDATA, slave_data(a));
      end
    end
    if (!done) check_eq("pready_timeout", 0, 1);
    @(posedge clk); #1;
    S_PSELx[m] = 1'b0;
    S_PENABLE[m] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    M_PREADY = 1'b0;
    M_PRDATA = 16'h0;
    S_PRESETn = 1'b0;
    S_PSELx = '0; S_PENABLE = '0; S_PWRITE = '0; S_PADDR = '0; S_PWDATA = '0;
    #1;
    check_eq("rst_psel", M_PSELx, 0);
    check_eq("rst_penable", M_PENABLE, 0);
    check_eq("rst_paddr", M_PADDR, 0);
    check_eq("rst_pready", S_PREADY, 0);
    check_eq("rst_grant", M_GRANT, 0);
    check_eq("rst_state", dbg_state, ARB_IDLE);
    do_reset();

    // 1: M0 write, zero wait states, cycle-accurate
    wait_states = 0;
    sb_push(0, 1'b1, 16'h0085, 16'hBEEF);
    S_PSELx[0] = 1'b1; S_PWRITE[0] = 1'b1; S_PADDR[15:0] = 16'h0085; S_PWDATA[15:0] = 16'hBEEF;
    @(posedge clk); #1;
    check_eq("t1_setup_state", dbg_state, ARB_SETUP);
    check_eq("t1_setup_psel", M_PSELx, 1);
    check_eq("t1_setup_penable", M_PENABLE, 0);
    check_eq("t1_setup_paddr", M_PADDR, 16'h0085);
    check_eq("t1_setup_pwdata", M_PWDATA, 16'hBEEF);
    check_eq("t1_setup_pwrite", M_PWRITE, 1);
    check_eq("t1_setup_pready", S_PREADY, 0);
    S_PENABLE[0] = 1'b1;
    S_PADDR[15:0] = 16'h7777;
    S_PWDATA[15:0] = 16'h0000;
    @(posedge clk); #1;
    check_eq("t1_access_psel", M_PSELx, 1);
    check_eq("t1_access_penable", M_PENABLE, 1);
    check_eq("t1_access_paddr_held", M_PADDR, 16'h0085);
    check_eq("t1_access_pwdata_held", M_PWDATA, 16'hBEEF);
    @(posedge clk); #1;
    check_eq("t1_done_pready", S_PREADY, 2'b01);
    check_eq("t1_done_psel", M_PSELx, 0);
    @(posedge clk); #1;
    S_PSELx[0] = 1'b0; S_PENABLE[0] = 1'b0;
    check_eq("t1_idle_state", dbg_state, ARB_IDLE);

    // 2: M1 read with 3 wait states
    wait_states = 3;
    pen_cycles = 0;
    sb_push(1, 1'b0, 16'h0093, 16'h0000);
    apb_req(1, 1'b0, 16'h0093, 16'h0000);
    check_eq("t2_penable_cycles", pen_cycles, 4);
    wait_states = 0;

    // 3: simultaneous requests after reset, M0 first
    do_reset();
    sb_push(0, 1'b1, 16'h0010, 16'h1111);
    sb_push(1, 1'b1, 16'h0020, 16'h2222);
    fork
      apb_req(0, 1'b1, 16'h0010, 16'h1111);
      apb_req(1, 1'b1, 16'h0020, 16'h2222);
    join

    // 4: continuous requests alternate 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      sb_push(0, 1'b0, 16'h0100 + 16'(k), 16'h0000);
      sb_push(1, 1'b1, 16'h0200 + 16'(k), 16'hC000 + 16'(k));
    end
    fork
      for (int k = 0; k < 3; k++) apb_req(0, 1'b0, 16'h0100 + 16'(k), 16'h0000);
      for (int k = 0; k < 3; k++) apb_req(1, 1'b1, 16'h0200 + 16'(k), 16'hC000 + 16'(k));
    join

    // 5: reset pulse mid-ACCESS; pointer returns to favouring M0
    sb_push(0, 1'b1, 16'h0300, 16'h3333);
    apb_req(0, 1'b1, 16'h0300, 16'h3333);
    wait_states = 5;
    S_PSELx[0] = 1'b1; S_PWRITE[0] = 1'b1; S_PADDR[15:0] = 16'h0400; S_PWDATA[15:0] = 16'h4444;
    @(posedge clk); #1;
    S_PENABLE[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_in_access", dbg_state, ARB_ACCESS);
    @(negedge clk);
    S_PRESETn = 1'b0;
    #1;
    check_eq("t5_rst_psel", M_PSELx, 0);
    check_eq("t5_rst_penable", M_PENABLE, 0);
    check_eq("t5_rst_pready", S_PREADY, 0);
    check_eq("t5_rst_state", dbg_state, ARB_IDLE);
    S_PSELx = '0; S_PENABLE = '0;
    @(negedge clk);
    S_PRESETn = 1'b1;
    @(posedge clk); #1;
    wait_states = 0;
    sb_push(0, 1'b1, 16'h0500, 16'h5555);
    sb_push(1, 1'b1, 16'h0600, 16'h6666);
    fork
      apb_req(0, 1'b1, 16'h0500, 16'h5555);
      apb_req(1, 1'b1, 16'h0600, 16'h6666);
    join

    // 6: M1 abandons during ACCESS; transfer finishes, M0 served next
    sb_push(0, 1'b1, 16'h0700, 16'h7777);
    apb_req(0, 1'b1, 16'h0700, 16'h7777);
    wait_states = 2;
    sb_push(1, 1'b1, 16'h0800, 16'h8888);
    sb_push(0, 1'b0, 16'h0900, 16'h0000);
    fork
      apb_req(0, 1'b0, 16'h0900, 16'h0000);
      begin
        S_PSELx[1] = 1'b1; S_PWRITE[1] = 1'b1; S_PADDR[31:16] = 16'h0800; S_PWDATA[31:16] = 16'h8888;
        @(posedge clk); #1;
        S_PENABLE[1] = 1'b1;
        @(posedge clk); #1;
        S_PSELx[1] = 1'b0; S_PENABLE[1] = 1'b0;
        m1_rdy = 0;
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (S_PREADY[1]) m1_rdy++;
        end
        check_eq("t6_abandon_no_pready", m1_rdy, 0);
      end
    join

    // Random solo transfers
    for (int k = 0; k < 8; k++) begin
      int m;
      logic wr;
      logic [15:0] a, d;
      m = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 65535));
      d = 16'($urandom_range(0, 65535));
      wait_states = $urandom_range(0, 3);
      sb_push(m, wr, a, d);
      apb_req(m, wr, a, d);
    end

    repeat (3) @(posedge clk);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
